// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the flip-flop register file.
package regfile_pkg;

  localparam int unsigned REGFILE_N = 32;
  localparam int unsigned REGFILE_W = 32;

  // Index width for an n-entry file; a single entry still needs a 1-bit port.
  function automatic int unsigned addr_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfile_word.sv
// One W-bit storage word with load enable and asynchronous active-high clear.
module regfile_word
  import regfile_pkg::*;
#(
  parameter int unsigned W = REGFILE_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_d;
  logic [W-1:0] q_q;

  always_comb begin
    q_d = q_q;
    if (en) q_d = d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/regfile_ff.sv
// Flip-flop register file: one write port, two combinational read ports,
// optional hardwired-zero register 0 and optional write-to-read forwarding.
module regfile_ff
  import regfile_pkg::*;
#(
  parameter int unsigned N        = REGFILE_N,
  parameter int unsigned W        = REGFILE_W,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wen,
  input  logic [addr_w(N)-1:0] waddr,
  input  logic [W-1:0]         wdata,
  input  logic [addr_w(N)-1:0] raddr1,
  input  logic [addr_w(N)-1:0] raddr2,
  output logic [W-1:0]         rdata1,
  output logic [W-1:0]         rdata2
);

  localparam int unsigned AW = addr_w(N);

  logic [W-1:0] word_q [N];
  logic         zero_hit_c;
  logic         fwd_ok_c;

  // Register 0 is a constant when hardwired, otherwise an ordinary word.
  for (genvar i = 0; i < N; i++) begin : g_word
    if (ZERO_REG && (i == 0)) begin : g_zero
      assign word_q[i] = '0;
    end else begin : g_ff
      regfile_word #(
        .W (W)
      ) u_word (
        .clk (clk),
        .rst (rst),
        .en  (wen && (waddr == AW'(i))),
        .d   (wdata),
        .q   (word_q[i])
      );
    end
  end

  // Forwarding never exposes a discarded write: not during reset, not to reg 0.
  assign zero_hit_c = ZERO_REG && (waddr == '0);
  assign fwd_ok_c   = BYPASS && wen && !rst && !zero_hit_c;

  always_comb begin
    rdata1 = word_q[raddr1];
    rdata2 = word_q[raddr2];
    if (fwd_ok_c && (raddr1 == waddr)) rdata1 = wdata;
    if (fwd_ok_c && (raddr2 == waddr)) rdata2 = wdata;
  end

endmodule

// File: tb/tb_regfile_ff.sv
// Randomized and directed checks of regfile_ff in three configurations
// against an array-based reference model.
module tb_regfile_ff;
  import regfile_pkg::*;

  localparam int unsigned N  = 32;
  localparam int unsigned W  = 32;
  localparam int unsigned AW = $clog2(N);

  logic          clk = 1'b0;
  logic          rst;
  logic          wen;
  logic [AW-1:0] waddr;
  logic [W-1:0]  wdata;
  logic [AW-1:0] raddr1;
  logic [AW-1:0] raddr2;
  logic [W-1:0]  obs1 [3];
  logic [W-1:0]  obs2 [3];

  // 0: zero-reg, no bypass; 1: zero-reg, bypass; 2: ordinary reg 0, bypass
  regfile_ff #(.N(N), .W(W), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_a (
    .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(obs1[0]), .rdata2(obs2[0]));
  regfile_ff #(.N(N), .W(W), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_b (
    .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(obs1[1]), .rdata2(obs2[1]));
  regfile_ff #(.N(N), .W(W), .ZERO_REG(1'b0), .BYPASS(1'b1)) dut_c (
    .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(obs1[2]), .rdata2(obs2[2]));

  always #5 clk = ~clk;

  logic [W-1:0] mem_z [N];
  logic [W-1:0] mem_o [N];
  int vectors;
  int miscompares;

  function automatic logic [W-1:0] exp_rd(input int k, input logic [AW-1:0] a);
    bit zero;
    bit byp;
    zero = (k < 2);
    byp  = (k > 0);
    if (rst) return '0;
    if (zero && a == '0) return '0;
    if (byp && wen && a == waddr) return wdata;
    return zero ? mem_z[a] : mem_o[a];
  endfunction

  task automatic clear_model();
    for (int i = 0; i < N; i++) begin
      mem_z[i] = '0;
      mem_o[i] = '0;
    end
  endtask

  // Advance one rising edge, committing the pre-edge inputs to the model.
  task automatic step();
    logic          s_rst;
    logic          s_wen;
    logic [AW-1:0] s_a;
    logic [W-1:0]  s_d;
    s_rst = rst; s_wen = wen; s_a = waddr; s_d = wdata;
    @(posedge clk);
    if (s_rst) clear_model();
    else if (s_wen) begin
      if (s_a != '0) mem_z[s_a] = s_d;
      mem_o[s_a] = s_d;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; wen = 1'b1; waddr = AW'(4); wdata = $urandom;
    raddr1 = AW'(4); raddr2 = '0;
    step(); step();
    #1;
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (obs1[k] !== exp_rd(k, raddr1)) begin
        miscompares++;
        $display("FAIL reset_hold dut%0d rdata1 got=%h exp=%h", k, obs1[k], exp_rd(k, raddr1));
      end
    end
    rst = 1'b0; wen = 1'b0;
    for (int i = 0; i < N; i++) begin
      raddr1 = AW'(i); raddr2 = AW'(N - 1 - i);
      #1;
      for (int k = 0; k < 3; k++) begin
        vectors++;
        if (obs1[k] !== exp_rd(k, raddr1) || obs2[k] !== exp_rd(k, raddr2)) begin
          miscompares++;
          $display("FAIL reset_clear dut%0d addr=%0d got=%h/%h exp=%h/%h", k, i,
                   obs1[k], obs2[k], exp_rd(k, raddr1), exp_rd(k, raddr2));
        end
      end
    end
  endtask

  task automatic test_write_pair();
    wen = 1'b1; waddr = AW'(1); wdata = 32'hA5A5A5A5; step();
    waddr = AW'(2); wdata = 32'h5A5A5A5A; step();
    wen = 1'b0; raddr1 = AW'(1); raddr2 = AW'(2);
    #1;
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (obs1[k] !== 32'hA5A5A5A5 || obs2[k] !== 32'h5A5A5A5A) begin
        miscompares++;
        $display("FAIL write_pair dut%0d got=%h/%h exp=a5a5a5a5/5a5a5a5a", k, obs1[k], obs2[k]);
      end
    end
  endtask

  task automatic test_fill_sweep();
    wen = 1'b1;
    for (int i = 0; i < N; i++) begin
      waddr = AW'(i); wdata = W'(i) * 32'h01010101;
      step();
    end
    wen = 1'b0;
    for (int i = 0; i < N; i++) begin
      for (int p = 0; p < 2; p++) begin
        raddr1 = AW'(i);
        raddr2 = (p == 0) ? AW'((i + 7) % N) : AW'(i);
        #1;
        for (int k = 0; k < 3; k++) begin
          vectors++;
          if (obs1[k] !== exp_rd(k, raddr1) || obs2[k] !== exp_rd(k, raddr2)) begin
            miscompares++;
            $display("FAIL fill_sweep dut%0d a1=%0d a2=%0d got=%h/%h exp=%h/%h", k, raddr1, raddr2,
                     obs1[k], obs2[k], exp_rd(k, raddr1), exp_rd(k, raddr2));
          end
        end
      end
    end
  endtask

  task automatic test_hold();
    wen = 1'b0; wdata = 32'hFFFFFFFF;
    for (int e = 0; e < 5; e++) begin
      for (int i = 0; i < N; i++) begin
        waddr = AW'(i);
        #0;
      end
      waddr = AW'($urandom_range(N - 1));
      step();
    end
    for (int i = 0; i < N; i++) begin
      raddr1 = AW'(i); raddr2 = AW'(i);
      #1;
      for (int k = 0; k < 3; k++) begin
        vectors++;
        if (obs1[k] !== exp_rd(k, raddr1) || obs2[k] !== exp_rd(k, raddr2)) begin
          miscompares++;
          $display("FAIL hold dut%0d addr=%0d got=%h/%h exp=%h", k, i, obs1[k], obs2[k],
                   exp_rd(k, raddr1));
        end
      end
    end
  endtask

  task automatic test_zero_reg();
    wen = 1'b1; waddr = '0; wdata = 32'hDEADBEEF; raddr1 = '0; raddr2 = '0;
    for (int ph = 0; ph < 2; ph++) begin
      #1;
      for (int k = 0; k < 3; k++) begin
        vectors++;
        if (obs1[k] !== exp_rd(k, '0) || obs2[k] !== exp_rd(k, '0)) begin
          miscompares++;
          $display("FAIL zero_reg ph%0d dut%0d got=%h/%h exp=%h", ph, k, obs1[k], obs2[k],
                   exp_rd(k, '0));
        end
      end
      if (ph == 0) begin
        step();
        wen = 1'b0;
      end
    end
  endtask

  task automatic test_bypass();
    wen = 1'b1; waddr = AW'(4); wdata = 32'hCAFEF00D; raddr1 = AW'(4); raddr2 = AW'(5);
    #1;
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (obs1[k] !== exp_rd(k, raddr1) || obs2[k] !== exp_rd(k, raddr2)) begin
        miscompares++;
        $display("FAIL bypass_pre dut%0d got=%h/%h exp=%h/%h", k, obs1[k], obs2[k],
                 exp_rd(k, raddr1), exp_rd(k, raddr2));
      end
    end
    step();
    wen = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (obs1[k] !== 32'hCAFEF00D) begin
        miscompares++;
        $display("FAIL bypass_post dut%0d got=%h exp=cafef00d", k, obs1[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] last;
    wen = 1'b1; waddr = AW'(9);
    for (int i = 0; i < 3; i++) begin
      wdata = $urandom; last = wdata;
      step();
    end
    waddr = AW'(10); wdata = $urandom; step();
    wen = 1'b0; raddr1 = AW'(9); raddr2 = AW'(10);
    #1;
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (obs1[k] !== last || obs2[k] !== exp_rd(k, raddr2)) begin
        miscompares++;
        $display("FAIL back_to_back dut%0d got=%h/%h exp=%h/%h", k, obs1[k], obs2[k], last,
                 exp_rd(k, raddr2));
      end
    end
  endtask

  task automatic test_async_reset();
    wen = 1'b1; waddr = AW'(3); wdata = 32'h12345678; step();
    wen = 1'b0; raddr1 = AW'(3); raddr2 = AW'(3);
    #1;
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (obs1[k] !== 32'h12345678) begin
        miscompares++;
        $display("FAIL areset_load dut%0d got=%h exp=12345678", k, obs1[k]);
      end
    end
    #2 rst = 1'b1;
    clear_model();
    #1;
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (obs1[k] !== '0 || obs2[k] !== '0) begin
        miscompares++;
        $display("FAIL areset_clear dut%0d got=%h/%h exp=0", k, obs1[k], obs2[k]);
      end
    end
    rst = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (obs1[k] !== '0) begin
        miscompares++;
        $display("FAIL areset_release dut%0d got=%h exp=0", k, obs1[k]);
      end
    end
    rst = 1'b1; wen = 1'b1; waddr = AW'(7); wdata = 32'h77777777; step();
    rst = 1'b0; wen = 1'b0; raddr1 = AW'(7);
    #1;
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (obs1[k] !== '0) begin
        miscompares++;
        $display("FAIL areset_discard dut%0d got=%h exp=0", k, obs1[k]);
      end
    end
    wen = 1'b1; waddr = AW'(3); wdata = 32'h0BADF00D; step();
    wen = 1'b0; raddr1 = AW'(3);
    #1;
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (obs1[k] !== 32'h0BADF00D) begin
        miscompares++;
        $display("FAIL areset_after dut%0d got=%h exp=0badf00d", k, obs1[k]);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst    = ($urandom_range(59) == 0);
      wen    = $urandom_range(1);
      waddr  = AW'($urandom_range(N - 1));
      wdata  = $urandom;
      raddr1 = ($urandom_range(3) == 0) ? waddr : AW'($urandom_range(N - 1));
      raddr2 = ($urandom_range(3) == 0) ? raddr1 : AW'($urandom_range(N - 1));
      #1;
      for (int k = 0; k < 3; k++) begin
        vectors++;
        if (obs1[k] !== exp_rd(k, raddr1) || obs2[k] !== exp_rd(k, raddr2)) begin
          miscompares++;
          $display("FAIL random c=%0d dut%0d a1=%0d a2=%0d got=%h/%h exp=%h/%h", c, k, raddr1,
                   raddr2, obs1[k], obs2[k], exp_rd(k, raddr1), exp_rd(k, raddr2));
        end
      end
      step();
    end
    rst = 1'b0; wen = 1'b0;
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst = 1'b1; wen = 1'b0; waddr = '0; wdata = '0; raddr1 = '0; raddr2 = '0;
    clear_model();
    test_reset();
    test_write_pair();
    test_fill_sweep();
    test_hold();
    test_zero_reg();
    test_bypass();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regfile_ff.md
REGFILE_FF -- requirements
Module: regfile_ff

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter N, 32, number of registers; SHALL be a power of two, 2..64.
REQ-003 Parameter W, 32, data width in bits; SHALL be 1..64.
REQ-004 Parameter ZERO_REG, 1, when 1 register 0 is hardwired to zero.
REQ-005 Parameter BYPASS, 0, when 1 a same-cycle write is forwarded to the read ports.
REQ-006 Port clk  input  1  clock; all state changes on its rising edge.
REQ-007 Port rst  input  1  asynchronous active-high reset.
REQ-008 Port wen  input  1  write enable.
REQ-009 Port waddr  input  $clog2(N)  write register index.
REQ-010 Port wdata  input  W  write data.
REQ-011 Port raddr1  input  $clog2(N)  read port 1 index.
REQ-012 Port raddr2  input  $clog2(N)  read port 2 index.
REQ-013 Port rdata1  output  W  read port 1 data.
REQ-014 Port rdata2  output  W  read port 2 data.

Function
REQ-015 Storage SHALL be N flip-flop registers of W bits each, with no inferred RAM macro.
REQ-016 On a rising clk edge with wen=1, reg[waddr] SHALL load wdata; all other registers SHALL hold.
REQ-017 On a rising clk edge with wen=0, no register SHALL change.
REQ-018 Reads SHALL be combinational: rdataK = reg[raddrK] with zero-cycle latency, changing within the same cycle raddrK changes.
REQ-019 A written value SHALL be visible on a read port immediately after the write edge, with one-cycle write-to-read latency.
REQ-020 With BYPASS=0, reading waddr while wen=1 SHALL return the old stored value until the edge.
REQ-021 With BYPASS=1, a read of a nonzero address equal to waddr while wen=1 SHALL return wdata combinationally.
REQ-022 Both read ports SHALL be independent; raddr1 = raddr2 SHALL return identical data.
REQ-023 With ZERO_REG=1, writes to index 0 SHALL be discarded, including the bypass path.
REQ-024 With ZERO_REG=1, reads of index 0 SHALL return 0.
REQ-025 With ZERO_REG=0, index 0 SHALL behave as an ordinary register.
REQ-026 Outputs SHALL never be X after reset for any in-range address.
REQ-027 Writes on consecutive cycles to different addresses SHALL each be committed; back-to-back writes to one address SHALL leave the last value.

Reset
REQ-028 Asserting rst SHALL immediately clear every register to 0, independent of clk.
REQ-029 While rst=1, writes SHALL be ignored and all read ports SHALL return 0.
REQ-030 After rst deasserts, the first write SHALL take effect on the next rising clk edge.
REQ-031 A reset asserted mid-sequence SHALL discard any write in the same cycle.

Structure
REQ-032 A shared package regfile_pkg SHALL hold the defaults REGFILE_N=32 and REGFILE_W=32 and the address-width function.
REQ-033 One sub-module, regfile_word (a single W-bit register with enable and async reset), SHALL be instantiated N times (N-1 when ZERO_REG=1).
REQ-034 Read multiplexing and the bypass compare SHALL live in the top module.

Verification
REQ-035 Write 0xA5A5A5A5 to reg 1, then 0x5A5A5A5A to reg 2, on consecutive edges; drop wen; set raddr1=1, raddr2=2 -> rdata1=0xA5A5A5A5, rdata2=0x5A5A5A5A.
REQ-036 With wen=0 and wdata=0xFFFFFFFF, toggle waddr over all indices for 5 edges -> all registers remain unchanged.
REQ-037 With ZERO_REG=1, write 0xDEADBEEF to reg 0; read reg 0 on both ports -> 0x00000000.
REQ-038 Fill regs 1..31 with value index*0x01010101; sweep both read ports across all indices -> each value matches, including raddr1=raddr2.
REQ-039 Load reg 3 with 0x12345678; pulse rst between clock edges -> rdata of reg 3 reads 0 before the next edge; a write after release commits.
REQ-040 With BYPASS=1, write reg 4 with 0xCAFEF00D while raddr1=4 -> rdata1=0xCAFEF00D in the same cycle; with BYPASS=0 -> old value until the edge.
